// File: rtl/wfg_interconnect_pkg.sv
// Shared types and constants for the Wishbone page-decoded interconnect.
package wfg_interconnect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  typedef enum logic {
    CAUSE_UNMAPPED = 1'b0,
    CAUSE_TIMEOUT  = 1'b1
  } err_cause_t;

  // Page 0 never selects a slave; slave k lives at page NULL_PAGE + k + 1.
  localparam int unsigned NULL_PAGE = 0;

endpackage

// File: rtl/wfg_wb_addr_decode.sv
// Combinational page decoder: one-hot slave select plus a mapped flag.
module wfg_wb_addr_decode
  import wfg_interconnect_pkg::*;
#(
  parameter int unsigned PW   = 28,
  parameter int unsigned NSLV = 4
) (
  input  logic [PW-1:0]   page,
  output logic [NSLV-1:0] sel,
  output logic            mapped
);

  always_comb begin
    sel = '0;
    for (int unsigned k = 0; k < NSLV; k++) begin
      sel[k] = (page == PW'(NULL_PAGE + k + 1));
    end
  end

  assign mapped = |sel;

endmodule

// File: rtl/wfg_interconnect.sv
// Single-master Wishbone interconnect: page decode, ack timeout, error status.
module wfg_interconnect
  import wfg_interconnect_pkg::*;
#(
  parameter int unsigned BUSW    = 32,
  parameter int unsigned NSLV    = 4,
  parameter int unsigned PAGEW   = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNTW    = 8
) (
  input  logic                 io_wbs_clk,
  input  logic                 io_wbs_rst,
  input  logic [BUSW-1:0]      io_wbs_adr,
  input  logic [BUSW-1:0]      io_wbs_datwr,
  input  logic                 io_wbs_we,
  input  logic                 io_wbs_stb,
  input  logic                 io_wbs_cyc,
  output logic [BUSW-1:0]      io_wbs_datrd,
  output logic                 io_wbs_ack,
  output logic                 io_wbs_err,
  output logic [NSLV-1:0]      s_stb_o,
  output logic                 s_cyc_o,
  output logic                 s_we_o,
  output logic [PAGEW-1:0]     s_adr_o,
  output logic [BUSW-1:0]      s_dat_o,
  input  logic [NSLV-1:0]      s_ack_i,
  input  logic [NSLV*BUSW-1:0] s_dat_i,
  output logic [BUSW-1:0]      err_addr_o,
  output logic                 err_cause_o,
  output logic [CNTW-1:0]      err_cnt_o
);

  localparam int unsigned PW = BUSW - PAGEW;
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  state_t          state, state_next;
  logic [CW-1:0]   wait_cnt, wait_cnt_next;
  logic [NSLV-1:0] sel;
  logic            mapped;
  logic            req;
  logic            slave_ack;
  logic [BUSW-1:0] slave_dat;

  logic [BUSW-1:0] datrd_next;
  logic            ack_next;
  logic            err_next;
  logic [BUSW-1:0] err_addr_next;
  logic            err_cause_next;
  logic [CNTW-1:0] err_cnt_next;

  wfg_wb_addr_decode #(
    .PW   (PW),
    .NSLV (NSLV)
  ) u_addr_decode (
    .page   (io_wbs_adr[BUSW-1:PAGEW]),
    .sel    (sel),
    .mapped (mapped)
  );

  assign req     = io_wbs_stb & io_wbs_cyc;
  assign s_adr_o = io_wbs_adr[PAGEW-1:0];
  assign s_dat_o = io_wbs_datwr;
  assign s_we_o  = io_wbs_we;
  assign s_cyc_o = io_wbs_cyc;

  // Strobe only while a request can still be accepted, never on the ack/err cycle.
  assign s_stb_o = (req && !io_wbs_rst && (state == IDLE || state == BUSY)) ? sel : '0;

  // Acks from slaves other than the addressed one are masked out here.
  assign slave_ack = |(s_ack_i & sel);

  always_comb begin
    slave_dat = '0;
    for (int unsigned k = 0; k < NSLV; k++) begin
      if (sel[k]) slave_dat |= s_dat_i[k*BUSW +: BUSW];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    datrd_next     = io_wbs_datrd;
    ack_next       = 1'b0;
    err_next       = 1'b0;
    err_addr_next  = err_addr_o;
    err_cause_next = err_cause_o;
    err_cnt_next   = err_cnt_o;

    unique case (state)
      IDLE: begin
        if (req) begin
          wait_cnt_next = '0;
          if (!mapped) begin
            state_next     = ERR;
            err_next       = 1'b1;
            err_cause_next = 1'(CAUSE_UNMAPPED);
            err_addr_next  = io_wbs_adr;
          end else if (slave_ack) begin
            state_next = DONE;
            ack_next   = 1'b1;
            datrd_next = slave_dat;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (!io_wbs_cyc) begin
          state_next = IDLE;
        end else if (slave_ack) begin
          state_next = DONE;
          ack_next   = 1'b1;
          datrd_next = slave_dat;
        end else if (wait_cnt == CW'(TIMEOUT - 2)) begin
          state_next     = ERR;
          err_next       = 1'b1;
          err_cause_next = 1'(CAUSE_TIMEOUT);
          err_addr_next  = io_wbs_adr;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Every entry to ERR clears read data and bumps the saturating counter.
    if (err_next) begin
      datrd_next = '0;
      if (err_cnt_o != CNT_MAX) err_cnt_next = err_cnt_o + 1'b1;
    end
  end

  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      io_wbs_datrd <= '0;
      io_wbs_ack   <= 1'b0;
      io_wbs_err   <= 1'b0;
      err_addr_o   <= '0;
      err_cause_o  <= 1'b0;
      err_cnt_o    <= '0;
    end else begin
      state        <= state_next;
      wait_cnt     <= wait_cnt_next;
      io_wbs_datrd <= datrd_next;
      io_wbs_ack   <= ack_next;
      io_wbs_err   <= err_next;
      err_addr_o   <= err_addr_next;
      err_cause_o  <= err_cause_next;
      err_cnt_o    <= err_cnt_next;
    end
  end

endmodule

// File: tb/tb_wfg_interconnect.sv
// Randomized self-checking bench for wfg_interconnect with a transaction-level model.
module tb_wfg_interconnect;

  localparam int BUSW    = 32;
  localparam int NSLV    = 4;
  localparam int PAGEW   = 4;
  localparam int TIMEOUT = 16;
  localparam int CNTW    = 2;
  localparam int CNT_MAX = 3;
  localparam int NEVER   = TIMEOUT + 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [BUSW-1:0]      adr, datwr;
  logic                 we, stb, cyc;
  logic [BUSW-1:0]      datrd;
  logic                 ack, err;
  logic [NSLV-1:0]      s_stb;
  logic                 s_cyc, s_we;
  logic [PAGEW-1:0]     s_adr;
  logic [BUSW-1:0]      s_dat_o;
  logic [NSLV-1:0]      s_ack;
  logic [NSLV*BUSW-1:0] s_dat_i;
  logic [BUSW-1:0]      err_addr;
  logic                 err_cause;
  logic [CNTW-1:0]      err_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [BUSW-1:0] m_datrd;
  logic [BUSW-1:0] m_err_addr;
  logic            m_cause;
  int              m_cnt;

  wfg_interconnect #(
    .BUSW(BUSW), .NSLV(NSLV), .PAGEW(PAGEW), .TIMEOUT(TIMEOUT), .CNTW(CNTW)
  ) dut (
    .io_wbs_clk(clk), .io_wbs_rst(rst), .io_wbs_adr(adr), .io_wbs_datwr(datwr),
    .io_wbs_we(we), .io_wbs_stb(stb), .io_wbs_cyc(cyc), .io_wbs_datrd(datrd),
    .io_wbs_ack(ack), .io_wbs_err(err), .s_stb_o(s_stb), .s_cyc_o(s_cyc),
    .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_ack_i(s_ack),
    .s_dat_i(s_dat_i), .err_addr_o(err_addr), .err_cause_o(err_cause),
    .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_datrd"}, 64'(datrd), 64'(m_datrd));
    chk({tag, "_eaddr"}, 64'(err_addr), 64'(m_err_addr));
    chk({tag, "_cause"}, 64'(err_cause), 64'(m_cause));
    chk({tag, "_ecnt"}, 64'(err_cnt), 64'(m_cnt));
  endtask

  task automatic model_clear();
    m_datrd = '0; m_err_addr = '0; m_cause = 1'b0; m_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; s_ack = '0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("rst_ackerr", 64'({ack, err}), 64'd0);
    chk_status("rst");
  endtask

  // One master transaction; lat = strobe-cycle index of the slave ack (>= TIMEOUT: never).
  task automatic do_tx(input logic [BUSW-1:0] a, input int lat, input logic [BUSW-1:0] dsel,
                       input logic [NSLV-1:0] extra, input int abort_at);
    int              page, s, resp;
    bit              mapped, acked;
    logic [NSLV-1:0] onehot;
    page   = int'(a[BUSW-1:PAGEW]);
    mapped = (page >= 1) && (page <= NSLV);
    s      = mapped ? page - 1 : 0;
    onehot = '0;
    if (mapped) onehot[s] = 1'b1;
    acked  = mapped && (lat < TIMEOUT);
    resp   = !mapped ? 1 : (acked ? lat + 1 : TIMEOUT);

    for (int k = 0; k < NSLV; k++) s_dat_i[k*BUSW +: BUSW] = $urandom;
    if (mapped) s_dat_i[s*BUSW +: BUSW] = dsel;
    adr = a; datwr = $urandom; we = 1'($urandom_range(0, 1)); stb = 1'b1; cyc = 1'b1;

    for (int i = 0; i < resp; i++) begin
      if (abort_at > 0 && i == abort_at) begin
        stb = 1'b0; cyc = 1'b0; s_ack = '0;
        #1;
        chk("abort_stb", 64'(s_stb), 64'd0);
        @(posedge clk); @(negedge clk);
        chk("abort_ackerr", 64'({ack, err}), 64'd0);
        chk_status("abort");
        @(posedge clk); @(negedge clk);
        chk("abort_idle", 64'({ack, err}), 64'd0);
        return;
      end
      s_ack = extra & ~onehot;
      if (acked && i == lat) s_ack[s] = 1'b1;
      #1;
      chk("s_stb", 64'(s_stb), 64'(onehot));
      if (i == 0) begin
        chk("s_adr", 64'(s_adr), 64'(a[PAGEW-1:0]));
        chk("s_pass", 64'({s_dat_o, s_we, s_cyc}), 64'({datwr, we, 1'b1}));
      end
      chk("wait_ackerr", 64'({ack, err}), 64'd0);
      chk("hold_datrd", 64'(datrd), 64'(m_datrd));
      @(posedge clk); @(negedge clk);
    end

    if (acked) begin
      m_datrd = dsel;
      chk("resp_ack", 64'({ack, err}), 64'b10);
    end else begin
      m_datrd    = '0;
      m_err_addr = a;
      m_cause    = mapped;
      m_cnt      = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      chk("resp_err", 64'({ack, err}), 64'b01);
    end
    chk("resp_stb", 64'(s_stb), 64'd0);
    chk_status("resp");
    stb = 1'b0; cyc = 1'b0; s_ack = '0;
    @(posedge clk); @(negedge clk);
    chk("post_ackerr", 64'({ack, err}), 64'd0);
  endtask

  // Enter BUSY on slave at address a, then reset mid-transaction.
  task automatic do_reset_mid(input logic [BUSW-1:0] a);
    adr = a; stb = 1'b1; cyc = 1'b1; s_ack = '0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_stb", 64'(s_stb), 64'd0);
    @(posedge clk); @(negedge clk);
    model_clear();
    chk("rstmid_ackerr", 64'({ack, err}), 64'd0);
    chk("rstmid_stb2", 64'(s_stb), 64'd0);
    chk_status("rstmid");
    rst = 1'b0; stb = 1'b0; cyc = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rstmid_idle", 64'({ack, err}), 64'd0);
  endtask

  initial begin
    rst = 1'b1; adr = '0; datwr = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
    s_ack = '0; s_dat_i = '0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Directed: slave 1 read with one cycle slave latency.
    do_tx(32'h24, 1, 32'hCAFE0001, '0, 0);
    chk("dir_read_data", 64'(datrd), 64'hCAFE0001);

    // Directed: null page then unmapped page.
    do_tx(32'h08, 0, 32'h0, '0, 0);
    do_tx(32'h60, 0, 32'h0, '0, 0);
    chk("dir_unmapped", 64'({err_cause, err_addr, err_cnt}), 64'({1'b0, 32'h60, 2'd2}));

    // Directed: slaves 0 and 3 ack together while slave 3 is addressed.
    do_tx(32'h4C, 2, 32'h3333_0003, 4'b0001, 0);

    // Directed: timeout on slave 2.
    do_reset();
    do_tx(32'h38, NEVER, 32'h0, '0, 0);
    chk("dir_timeout", 64'({err_cause, err_cnt}), 64'({1'b1, 2'd1}));

    // Directed: cyc dropped in BUSY, then reset in BUSY.
    do_tx(32'h14, NEVER, 32'h0, '0, 3);
    do_reset_mid(32'h2C);

    // Directed: error counter saturation.
    for (int n = 0; n < 5; n++) do_tx(32'h70 + 32'(n), 0, 32'h0, '0, 0);
    chk("dir_saturate", 64'(err_cnt), 64'd3);

    // Random transactions.
    do_reset();
    for (int n = 0; n < 150; n++) begin
      logic [BUSW-1:0] a;
      int              r, lat, ab;
      a = {24'h0, 4'($urandom_range(0, 7)), 4'($urandom)};
      if ($urandom_range(0, 9) == 0) a[BUSW-1:8] = 24'($urandom);
      r   = int'($urandom_range(0, 9));
      lat = (r < 6) ? int'($urandom_range(0, 3)) :
            (r < 8) ? int'($urandom_range(4, TIMEOUT - 1)) : NEVER;
      ab  = 0;
      if ($urandom_range(0, 9) == 0) begin
        lat = NEVER;
        ab  = int'($urandom_range(1, TIMEOUT - 2));
      end
      do_tx(a, lat, $urandom, 4'($urandom), ab);
      if ($urandom_range(0, 19) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wfg_interconnect.md
WFG_INTERCONNECT -- requirements
Module: wfg_interconnect

Interface
REQ-001 SHALL have parameter BUSW, default 32: Wishbone address/data width.
REQ-002 SHALL have parameter NSLV, default 4: number of slave ports, range 1..15.
REQ-003 SHALL have parameter PAGEW, default 4: offset bits per page; page index = io_wbs_adr[BUSW-1:PAGEW].
REQ-004 SHALL have parameter TIMEOUT, default 16: slave wait cycles before timeout error, minimum 2.
REQ-005 SHALL have parameter CNTW, default 8: error counter width.
REQ-006 SHALL have port io_wbs_clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port io_wbs_rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have ports io_wbs_adr, input, BUSW / io_wbs_datwr, input, BUSW / io_wbs_we, io_wbs_stb, io_wbs_cyc, inputs, 1 each: master request.
REQ-009 SHALL have ports io_wbs_datrd, output, BUSW / io_wbs_ack, output, 1 / io_wbs_err, output, 1: master response.
REQ-010 SHALL have ports s_stb_o, output, NSLV / s_cyc_o, s_we_o, outputs, 1 each / s_adr_o, output, PAGEW / s_dat_o, output, BUSW: slave request.
REQ-011 SHALL have ports s_ack_i, input, NSLV / s_dat_i, input, NSLV*BUSW, slave k at bits [k*BUSW +: BUSW]: slave response.
REQ-012 SHALL have ports err_addr_o, output, BUSW / err_cause_o, output, 1 (0 unmapped, 1 timeout) / err_cnt_o, output, CNTW: error status.

Function
REQ-013 Page 0 SHALL be the null page; slave k SHALL be selected when page index == k+1; any other page SHALL be unmapped.
REQ-014 s_adr_o SHALL equal io_wbs_adr[PAGEW-1:0]; s_dat_o, s_we_o and s_cyc_o SHALL pass io_wbs_datwr, io_wbs_we and io_wbs_cyc combinationally.
REQ-015 The FSM SHALL have states IDLE, BUSY, DONE, ERR.
REQ-016 s_stb_o[k] SHALL equal io_wbs_stb & io_wbs_cyc & sel[k] in IDLE and BUSY, and 0 in DONE and ERR; at most one bit SHALL be high.
REQ-017 IDLE, stb&cyc mapped: wait counter := 0; no s_ack_i[k] -> BUSY; s_ack_i[k] -> DONE.
REQ-018 IDLE, stb&cyc unmapped -> ERR, with err_cause_o := 0 and err_addr_o := io_wbs_adr.
REQ-019 BUSY: s_ack_i[k] of the selected slave -> DONE; otherwise the counter increments; on reaching TIMEOUT-1 -> ERR with err_cause_o := 1 and err_addr_o := io_wbs_adr.
REQ-020 On every transition to DONE, io_wbs_datrd SHALL register the selected slave's s_dat_i slice, and io_wbs_ack SHALL be high exactly the following cycle (DONE), giving one cycle latency after slave ack.
REQ-021 io_wbs_err SHALL be high for exactly the ERR cycle; io_wbs_ack and io_wbs_err SHALL never be high together.
REQ-022 DONE and ERR SHALL each last one cycle, then return to IDLE, so a held stb is not re-issued on the ack/err cycle.
REQ-023 s_ack_i bits of unselected slaves SHALL be ignored in all states.
REQ-024 io_wbs_cyc low in BUSY SHALL abort to IDLE with no ack, no err, and no status update.
REQ-025 Each entry to ERR SHALL increment err_cnt_o, saturating at 2^CNTW-1.
REQ-026 io_wbs_datrd SHALL hold its value outside DONE updates; it SHALL be 0 after an ERR.

Reset
REQ-027 io_wbs_rst high at a clock edge SHALL force state IDLE, counter 0, io_wbs_datrd/io_wbs_ack/io_wbs_err/err_addr_o/err_cause_o/err_cnt_o to 0; s_stb_o SHALL be 0 while reset is high.
REQ-028 Reset mid-transaction SHALL discard the transaction with no ack or err.

Structure
REQ-029 Package wfg_interconnect_pkg SHALL hold the FSM state enum, the error-cause enum and the null-page constant.
REQ-030 Page decoding SHALL be one combinational sub-module, wfg_wb_addr_decode, producing the one-hot sel vector and a mapped flag; the FSM, counter and response mux SHALL stay in wfg_interconnect.

Verification
REQ-031 NSLV=4: read 0x24, slave 1 acks 1 cycle after stb with 0xCAFE0001 -> s_stb_o=0010, s_adr_o=4, io_wbs_ack 1 cycle later, io_wbs_datrd=0xCAFE0001.
REQ-032 Access 0x08 (null page) and 0x60 (page 6) -> io_wbs_err 1 cycle after stb each, no s_stb_o, err_cause_o=0, err_addr_o=0x60, err_cnt_o=2.
REQ-033 TIMEOUT=16, slave 2 never acks -> io_wbs_err after 16 strobe cycles, s_stb_o low during ERR, err_cause_o=1, err_cnt_o=1.
REQ-034 Slaves 0 and 3 ack together while slave 3 is selected -> data from slave 3 only, single ack.
REQ-035 io_wbs_cyc dropped in BUSY, then io_wbs_rst asserted in BUSY -> no ack or err, FSM IDLE, all outputs 0 after reset.
REQ-036 CNTW=2, 5 unmapped accesses -> err_cnt_o saturates at 3.
